// File: rtl/pll_sup_pkg.sv
// Shared encodings and widths for the PLL lock supervisor.
package pll_sup_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

    typedef enum logic [STATE_W-1:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_READY     = 3'd3,
        S_FAIL      = 3'd4
    } pll_state_e;

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Control and status bundle between the PLL supervisor and its surroundings.
interface pll_lock_supervisor_if;
    import pll_sup_pkg::*;

    logic                 pll_locked;
    logic                 restart;
    logic                 loss_clr;
    logic                 pll_rst;
    logic                 clk_ready;
    logic                 fail;
    pll_state_e           state;
    logic [RETRY_W-1:0]   retry_count;
    logic [LOSS_W-1:0]    loss_count;

    modport master (
        output pll_locked, restart, loss_clr,
        input  pll_rst, clk_ready, fail, state, retry_count, loss_count
    );

    modport slave (
        input  pll_locked, restart, loss_clr,
        output pll_rst, clk_ready, fail, state, retry_count, loss_count
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level signals.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock wait with bounded retries, and lock qualification.
//
// state       | meaning
// RESET_PLL   | holding pll_rst high for RST_CYCLES
// WAIT_LOCK   | pll_rst released, waiting up to LOCK_TIMEOUT for lock
// STABLE      | lock seen, requiring STABLE_CYCLES of continuous lock
// READY       | lock qualified, clk_ready asserted
// FAIL        | retries exhausted, PLL held in reset until restart
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 17
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.slave  bus
);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES - 1);

    pll_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [RETRY_W-1:0]  retry_q;
    logic [LOSS_W-1:0]   loss_q;
    logic                pll_rst_q;
    logic                clk_ready_q;
    logic                fail_q;
    logic                locked_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    // Outputs are set alongside each transition so they track the state register.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            clk_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else if (bus.restart) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            clk_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= S_WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q <= S_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q == RETRY_LAST) begin
                            state_q <= S_FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= S_RESET_PLL;
                            retry_q <= retry_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    // A dropout here is a glitch, not a failed attempt.
                    if (!locked_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q     <= S_READY;
                        cnt_q       <= '0;
                        retry_q     <= '0;
                        clk_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_READY: begin
                    if (!locked_s) begin
                        state_q     <= S_RESET_PLL;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        clk_ready_q <= 1'b0;
                    end
                end
                S_FAIL: begin
                    pll_rst_q   <= 1'b1;
                    clk_ready_q <= 1'b0;
                    fail_q      <= 1'b1;
                end
                default: begin
                    state_q     <= S_RESET_PLL;
                    cnt_q       <= '0;
                    retry_q     <= '0;
                    pll_rst_q   <= 1'b1;
                    clk_ready_q <= 1'b0;
                    fail_q      <= 1'b0;
                end
            endcase
        end
    end

    // Loss counting is independent of restart so a coincident loss is still recorded.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (bus.loss_clr) begin
            loss_q <= '0;
        end else if (state_q == S_READY && !locked_s && loss_q != LOSS_MAX) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign bus.state       = state_q;
    assign bus.pll_rst     = pll_rst_q;
    assign bus.clk_ready   = clk_ready_q;
    assign bus.fail        = fail_q;
    assign bus.retry_count = retry_q;
    assign bus.loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RST=4, TIMEOUT=20, STABLE=8, RETRIES=3.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    logic refclk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n;
    int   timeouts;

    pll_lock_supervisor_if bus ();

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .CNT_W         (17)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rst_low(input int max, output int cnt);
        cnt = 0;
        while (bus.pll_rst !== 1'b0 && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_ready(input logic val, input int max, output int cnt);
        cnt = 0;
        while (bus.clk_ready !== val && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    // PLL model: lock comes back as soon as pll_rst is released.
    task automatic relock(output logic ok);
        int c1, c2;
        wait_rst_low(100, c1);
        bus.pll_locked = 1'b1;
        wait_ready(1'b1, 100, c2);
        ok = (c1 < 100) && (c2 < 100);
    endtask

    initial begin
        logic ok;
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        bus.loss_clr   = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_state", bus.state, 0);
        check("rst_pll_rst", bus.pll_rst, 1);
        check("rst_clk_ready", bus.clk_ready, 0);
        check("rst_fail", bus.fail, 0);
        check("rst_retry", bus.retry_count, 0);
        check("rst_loss", bus.loss_count, 0);

        // 1: nominal bring-up, lock 5 cycles after pll_rst falls
        rst_n = 1'b1;
        wait_rst_low(50, n);
        check("t1_pll_rst_len", n, 4);
        check("t1_wait_state", bus.state, 1);
        repeat (5) tick();
        bus.pll_locked = 1'b1;
        wait_ready(1'b1, 50, n);
        check("t1_ready_latency", 5 + n, 16);
        check("t1_ready_state", bus.state, 3);
        check("t1_retry", bus.retry_count, 0);
        check("t1_pll_rst_low", bus.pll_rst, 0);

        // 3: one-cycle lock glitch at stable count 5
        bus.restart    = 1'b1;
        bus.pll_locked = 1'b0;
        tick();
        bus.restart    = 1'b0;
        check("t3_restart_state", bus.state, 0);
        check("t3_restart_ready", bus.clk_ready, 0);
        check("t3_no_loss", bus.loss_count, 0);
        wait_rst_low(50, n);
        check("t3_pll_rst_len", n, 4);
        bus.pll_locked = 1'b1;
        n = 0;
        while (bus.state !== S_STABLE && n < 20) begin
            tick();
            n++;
        end
        check("t3_stable_entry", n, 3);
        repeat (3) tick();
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        repeat (2) tick();
        check("t3_glitch_state", bus.state, 1);
        check("t3_glitch_retry", bus.retry_count, 0);
        check("t3_glitch_ready", bus.clk_ready, 0);
        tick();
        check("t3_restable", bus.state, 2);
        wait_ready(1'b1, 50, n);
        check("t3_fresh_stable", n, 8);

        // 4: repeated losses from READY, saturation at 255
        timeouts = 0;
        for (int i = 1; i <= 300; i++) begin
            bus.pll_locked = 1'b0;
            wait_ready(1'b0, 10, n);
            if (n >= 10) timeouts++;
            // two synchronizer edges plus the state register edge
            if (i == 1) check("t4_drop_latency", n, 3);
            relock(ok);
            if (!ok) timeouts++;
            if (i == 1)   check("t4_loss_1", bus.loss_count, 1);
            if (i == 254) check("t4_loss_254", bus.loss_count, 254);
            if (i == 255) check("t4_loss_255", bus.loss_count, 255);
            if (i == 256) check("t4_loss_sat", bus.loss_count, 255);
        end
        check("t4_loop_timeouts", timeouts, 0);
        check("t4_loss_300", bus.loss_count, 255);
        bus.loss_clr = 1'b1;
        tick();
        bus.loss_clr = 1'b0;
        check("t4_loss_clr", bus.loss_count, 0);
        check("t4_still_ready", bus.clk_ready, 1);

        // 5a: restart coincident with a READY loss
        bus.pll_locked = 1'b0;
        repeat (2) tick();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        check("t5_restart_state", bus.state, 0);
        check("t5_restart_loss", bus.loss_count, 1);
        check("t5_restart_ready", bus.clk_ready, 0);
        relock(ok);
        check("t5_relock", ok, 1);

        // 5b: loss_clr coincident with a loss
        bus.pll_locked = 1'b0;
        repeat (2) tick();
        bus.loss_clr = 1'b1;
        tick();
        bus.loss_clr = 1'b0;
        check("t5_clr_wins", bus.loss_count, 0);
        check("t5_clr_state", bus.state, 0);

        // 2: lock never arrives, three attempts then FAIL
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        repeat (23) tick();
        check("t2_a0_wait", bus.state, 1);
        check("t2_a0_retry", bus.retry_count, 0);
        tick();
        check("t2_a1_state", bus.state, 0);
        check("t2_a1_retry", bus.retry_count, 1);
        repeat (24) tick();
        check("t2_a2_state", bus.state, 0);
        check("t2_a2_retry", bus.retry_count, 2);
        repeat (23) tick();
        check("t2_pre_fail_state", bus.state, 1);
        check("t2_pre_fail", bus.fail, 0);
        tick();
        check("t2_fail_state", bus.state, 4);
        check("t2_fail", bus.fail, 1);
        check("t2_fail_pll_rst", bus.pll_rst, 1);
        repeat (30) tick();
        check("t2_fail_hold", bus.state, 4);
        check("t2_fail_hold_flag", bus.fail, 1);
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        check("t2_restart_state", bus.state, 0);
        check("t2_restart_fail", bus.fail, 0);
        check("t2_restart_retry", bus.retry_count, 0);

        // 6: asynchronous reset in the middle of WAIT_LOCK
        repeat (24) tick();
        check("t6_retry_pre", bus.retry_count, 1);
        repeat (9) tick();
        check("t6_wait_pre", bus.state, 1);
        check("t6_pll_rst_pre", bus.pll_rst, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_state", bus.state, 0);
        check("t6_async_pll_rst", bus.pll_rst, 1);
        check("t6_async_ready", bus.clk_ready, 0);
        check("t6_async_retry", bus.retry_count, 0);
        check("t6_async_loss", bus.loss_count, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
